// File: rtl/cpu_pkg.sv
// Shared RV32I sequencer definitions: state encoding, branch funct3 codes and trap vector.
// TRAP_VEC is only consumed when CPU_SEQ_MISALIGN_TRAP_EN is defined.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH      = 3'd0,
      S_FETCH_WAIT = 3'd1,
      S_DECODE     = 3'd2,
      S_REG_READ   = 3'd3,
      S_OPERAND    = 3'd4,
      S_EXECUTE    = 3'd5,
      S_MEM        = 3'd6,
      S_WRITEBACK  = 3'd7
   } state_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: rs1 vs rs2 selected by funct3.
// Reserved codes 010/011 never report taken.
module branch_cmp
   import cpu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (rs1_val == rs2_val);
         F3_BNE:  taken = (rs1_val != rs2_val);
         F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         F3_BLTU: taken = (rs1_val <  rs2_val);
         F3_BGEU: taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32I sequencer: owns the PC, steps fetch..writeback, drives memory handshakes.
// Optional misaligned-access trap (with extra `trap` output) enabled by CPU_SEQ_MISALIGN_TRAP_EN.
module cpu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_TIMEOUT = 0
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        is_lui,
   input  logic        is_auipc,
   input  logic        rd_nonzero,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_address,
   input  logic        dmem_ready,
   output logic [2:0]  state,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic        rf_we,
   output logic        retire
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
  ,output logic        trap
`endif
);

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] dmem_addr_reg;
   logic [31:0] wait_cnt_reg;
   logic [31:0] wait_next;
   logic [31:0] pc_next;
   logic        taken_reg;
   logic        jump_reg;
   logic        trap_pend_reg;
   logic        cmp_taken;
   logic        branch_taken;
   logic        misalign;
   logic        writes_rd;

   // lui/auipc sequence exactly like ALU ops and the ALU result goes straight to the register file.
   logic unused_inputs;
   assign unused_inputs = ^{is_lui, is_auipc, alu_result};

   branch_cmp u_branch_cmp (
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .taken   (cmp_taken)
   );

   assign branch_taken = is_branch & cmp_taken;
   assign writes_rd    = rd_nonzero & ~(is_store | is_branch);
   assign wait_next    = wait_cnt_reg + 32'd1;

`ifdef CPU_SEQ_MISALIGN_TRAP_EN
   assign misalign = ((is_load | is_store) &
                      (((funct3[1:0] == 2'b10) & (alu_address[1:0] != 2'b00)) |
                       ((funct3[1:0] == 2'b01) & alu_address[0]))) |
                     ((is_jal | is_jalr | branch_taken) & alu_address[1]);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      pc_next = pc_reg + 32'd4;
      if (trap_pend_reg)
         pc_next = TRAP_VEC;
      else if (jump_reg)
         pc_next = {dmem_addr_reg[31:1], 1'b0};
      else if (taken_reg)
         pc_next = dmem_addr_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_FETCH;
         pc_reg        <= RESET_PC;
         dmem_addr_reg <= 32'd0;
         wait_cnt_reg  <= 32'd0;
         taken_reg     <= 1'b0;
         jump_reg      <= 1'b0;
         trap_pend_reg <= 1'b0;
         imem_req      <= 1'b0;
         ir_we         <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         rf_we         <= 1'b0;
         retire        <= 1'b0;
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
         trap          <= 1'b0;
`endif
      end else begin
         ir_we  <= 1'b0;
         rf_we  <= 1'b0;
         retire <= 1'b0;
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
         trap   <= 1'b0;
`endif
         case (state_reg)
            S_FETCH: begin
               state_reg    <= S_FETCH_WAIT;
               imem_req     <= 1'b1;
               wait_cnt_reg <= 32'd0;
            end
            S_FETCH_WAIT: begin
               if (imem_ready) begin
                  state_reg <= S_DECODE;
                  imem_req  <= 1'b0;
                  ir_we     <= 1'b1;
               end else if ((IMEM_TIMEOUT != 0) && (wait_next == IMEM_TIMEOUT)) begin
                  state_reg <= S_FETCH;
                  imem_req  <= 1'b0;
               end else begin
                  wait_cnt_reg <= wait_next;
               end
            end
            S_DECODE:   state_reg <= S_REG_READ;
            S_REG_READ: state_reg <= S_OPERAND;
            S_OPERAND:  state_reg <= S_EXECUTE;
            S_EXECUTE: begin
               dmem_addr_reg <= alu_address;
               taken_reg     <= branch_taken;
               jump_reg      <= is_jal | is_jalr;
               trap_pend_reg <= misalign;
               // A trapped access never reaches the bus and never writes rd.
               if ((is_load | is_store) & ~misalign) begin
                  state_reg <= S_MEM;
                  dmem_req  <= 1'b1;
                  dmem_we   <= is_store;
               end else begin
                  state_reg <= S_WRITEBACK;
                  rf_we     <= writes_rd & ~misalign;
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state_reg <= S_WRITEBACK;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  rf_we     <= writes_rd;
               end
            end
            S_WRITEBACK: begin
               state_reg <= S_FETCH;
               retire    <= 1'b1;
               pc_reg    <= pc_next;
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
               trap      <= trap_pend_reg;
`endif
            end
            default: state_reg <= S_FETCH;
         endcase
      end
   end

   assign state     = state_reg;
   assign pc        = pc_reg;
   assign dmem_addr = dmem_addr_reg;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: instruction vector table, expected-result queue, and
// hand-written reset-during-MEM and PC-wrap sequences. Honors CPU_SEQ_MISALIGN_TRAP_EN.
module tb_cpu_seq_ctrl;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic        imem_ready;
   logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
   logic        rd_nonzero;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val, alu_result, alu_address;
   logic        dmem_ready;
   logic [2:0]  state;
   logic [31:0] pc;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, retire;
   logic [31:0] dmem_addr;
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
   logic        trap;
`endif

   cpu_seq_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_ready  (imem_ready),
      .is_load     (is_load),
      .is_store    (is_store),
      .is_branch   (is_branch),
      .is_jal      (is_jal),
      .is_jalr     (is_jalr),
      .is_lui      (is_lui),
      .is_auipc    (is_auipc),
      .rd_nonzero  (rd_nonzero),
      .funct3      (funct3),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .alu_result  (alu_result),
      .alu_address (alu_address),
      .dmem_ready  (dmem_ready),
      .state       (state),
      .pc          (pc),
      .imem_req    (imem_req),
      .ir_we       (ir_we),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .rf_we       (rf_we),
      .retire      (retire)
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
     ,.trap        (trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction class bits: {load, store, branch, jal, jalr}
   localparam logic [4:0] C_ALU  = 5'b00000;
   localparam logic [4:0] C_LD   = 5'b10000;
   localparam logic [4:0] C_ST   = 5'b01000;
   localparam logic [4:0] C_BR   = 5'b00100;
   localparam logic [4:0] C_JAL  = 5'b00010;
   localparam logic [4:0] C_JALR = 5'b00001;

   typedef struct {
      string       name;
      logic [4:0]  cls;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] addr;
      logic        rdnz;
      int          iw;
      int          dd;
      logic [31:0] epc;
      logic        erf;
      logic        edwe;
      int          emem;
      int          elat;
      logic        etrap;
   } vec_t;

   vec_t tbl[16];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   trace[64];

   function automatic vec_t mk(string name, logic [4:0] cls, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] b, logic [31:0] addr, logic rdnz, int iw, int dd,
                               logic [31:0] epc, logic erf, logic edwe, int emem, int elat,
                               logic etrap);
      vec_t v;
      v.name = name; v.cls = cls; v.f3 = f3; v.a = a; v.b = b; v.addr = addr; v.rdnz = rdnz;
      v.iw = iw; v.dd = dd; v.epc = epc; v.erf = erf; v.edwe = edwe; v.emem = emem;
      v.elat = elat; v.etrap = etrap;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      {is_load, is_store, is_branch, is_jal, is_jalr} = v.cls;
      funct3      = v.f3;
      rs1_val     = v.a;
      rs2_val     = v.b;
      alu_address = v.addr;
      alu_result  = ~v.addr;
      rd_nonzero  = v.rdnz;
      imem_ready  = 1'b0;
      dmem_ready  = 1'b0;
   endtask

   // Called at the falling edge of a FETCH cycle; runs one instruction to its retire pulse.
   task automatic run_vec(input vec_t v);
      int          cyc = 0;
      int          mem_c = 0;
      int          fw_c = 0;
      int          ir_c = 0;
      int          inv_bad = 0;
      int          wb_rf = 0;
      logic        dwe_seen = 1'b0;
      logic [31:0] daddr_seen = 32'd0;
      logic        done = 1'b0;
      vec_t        e;
      drive(v);
      exp_q.push_back(v);
      trace[0] = int'(state);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc < 64) trace[cyc] = int'(state);
         if (imem_req !== (state == S_FETCH_WAIT)) inv_bad++;
         if (dmem_req !== (state == S_MEM)) inv_bad++;
         if (rf_we && state != S_WRITEBACK) inv_bad++;
         if (ir_we) begin
            ir_c++;
            if (state != S_DECODE) inv_bad++;
         end
         if (state == S_FETCH_WAIT) begin
            fw_c++;
            imem_ready = (fw_c > v.iw);
         end else if (state == S_MEM) begin
            mem_c++;
            dwe_seen   = dwe_seen | dmem_we;
            daddr_seen = dmem_addr;
            dmem_ready = (mem_c >= v.dd);
         end else if (state == S_WRITEBACK) begin
            if (rf_we) wb_rf++;
            dmem_ready = 1'b0;
         end
         if (retire) begin
            done = 1'b1;
            if (exp_q.size() == 0) begin
               chk({v.name, " queue"}, 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, " pc"}, pc, e.epc);
               chk({e.name, " rf_we"}, 32'(wb_rf), 32'(e.erf));
               chk({e.name, " dmem_we"}, 32'(dwe_seen), 32'(e.edwe));
               chk({e.name, " mem_cycles"}, 32'(mem_c), 32'(e.emem));
               chk({e.name, " latency"}, 32'(cyc), 32'(e.elat));
               chk({e.name, " ir_we"}, 32'(ir_c), 32'd1);
               chk({e.name, " handshake"}, 32'(inv_bad), 32'd0);
               if (e.emem > 0) chk({e.name, " dmem_addr"}, daddr_seen, e.addr);
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
               chk({e.name, " trap"}, 32'(trap), 32'(e.etrap));
`endif
               $display("txn %-10s pc=%h lat=%0d mem=%0d rf_we=%0d dmem_we=%0d", e.name, pc,
                        cyc, mem_c, wb_rf, dwe_seen);
            end
         end
      end
      if (!done) begin
         void'(exp_q.pop_front());
         chk({v.name, " retire timeout"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int   exp_trace[8];
      int   mem_wait;
      vec_t v;
      exp_trace = '{0, 1, 2, 3, 4, 5, 7, 0};

      tbl[0]  = mk("addi",   C_ALU, 3'b000, 0, 0, 32'h1234, 1, 0, 0, 32'h4,   1, 0, 0, 7, 0);
      tbl[1]  = mk("beq_t",  C_BR,  3'b000, 5, 5, 32'h40,   1, 0, 0, 32'h40,  0, 0, 0, 7, 0);
      tbl[2]  = mk("beq_nt", C_BR,  3'b000, 5, 6, 32'h80,   1, 0, 0, 32'h44,  0, 0, 0, 7, 0);
      tbl[3]  = mk("blt_t",  C_BR,  3'b100, 32'hFFFF_FFFF, 1, 32'h200, 1, 0, 0, 32'h200, 0, 0, 0, 7, 0);
      tbl[4]  = mk("bltu_nt",C_BR,  3'b110, 32'hFFFF_FFFF, 1, 32'h300, 1, 0, 0, 32'h204, 0, 0, 0, 7, 0);
      tbl[5]  = mk("bne_t",  C_BR,  3'b001, 1, 2, 32'h400,  1, 0, 0, 32'h400, 0, 0, 0, 7, 0);
      tbl[6]  = mk("bge_t",  C_BR,  3'b101, 1, 32'hFFFF_FFFF, 32'h500, 1, 0, 0, 32'h500, 0, 0, 0, 7, 0);
      tbl[7]  = mk("bgeu_nt",C_BR,  3'b111, 1, 32'hFFFF_FFFF, 32'h600, 1, 0, 0, 32'h504, 0, 0, 0, 7, 0);
      tbl[8]  = mk("br_f010",C_BR,  3'b010, 7, 7, 32'h700,  1, 0, 0, 32'h508, 0, 0, 0, 7, 0);
      tbl[9]  = mk("lw_d3",  C_LD,  3'b010, 0, 0, 32'h1000, 1, 0, 3, 32'h50C, 1, 0, 3, 10, 0);
      tbl[10] = mk("sw",     C_ST,  3'b010, 0, 0, 32'h2000, 1, 0, 1, 32'h510, 0, 1, 1, 8, 0);
      tbl[11] = mk("addi_iw",C_ALU, 3'b000, 0, 0, 32'h0,    1, 2, 0, 32'h514, 1, 0, 0, 9, 0);
`ifdef CPU_SEQ_MISALIGN_TRAP_EN
      tbl[12] = mk("jalr_x0",C_JALR,3'b000, 0, 0, 32'h1003, 0, 0, 0, 32'h100, 0, 0, 0, 7, 1);
      tbl[13] = mk("jal",    C_JAL, 3'b000, 0, 0, 32'h3000, 1, 0, 0, 32'h3000,1, 0, 0, 7, 0);
      tbl[14] = mk("lw_mis", C_LD,  3'b010, 0, 0, 32'h102,  1, 0, 1, 32'h100, 0, 0, 0, 7, 1);
      tbl[15] = mk("lb_odd", C_LD,  3'b000, 0, 0, 32'h103,  1, 0, 2, 32'h104, 1, 0, 2, 9, 0);
`else
      tbl[12] = mk("jalr_x0",C_JALR,3'b000, 0, 0, 32'h1003, 0, 0, 0, 32'h1002,0, 0, 0, 7, 0);
      tbl[13] = mk("jal",    C_JAL, 3'b000, 0, 0, 32'h3000, 1, 0, 0, 32'h3000,1, 0, 0, 7, 0);
      tbl[14] = mk("lw_mis", C_LD,  3'b010, 0, 0, 32'h102,  1, 0, 1, 32'h3004,1, 0, 1, 8, 0);
      tbl[15] = mk("lb_odd", C_LD,  3'b000, 0, 0, 32'h103,  1, 0, 2, 32'h3008,1, 0, 2, 9, 0);
`endif

      rst = 1'b1;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      is_load = 0; is_store = 0; is_branch = 0; is_jal = 0; is_jalr = 0; is_lui = 0; is_auipc = 0;
      rd_nonzero = 0; funct3 = 0; rs1_val = 0; rs2_val = 0; alu_result = 0; alu_address = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst state", 32'(state), 32'(S_FETCH));
      chk("rst pc", pc, 32'h0);
      chk("rst outputs", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, retire}), 32'd0);
      chk("rst dmem_addr", dmem_addr, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_vec(tbl[i]);
         if (i == 0) begin
            for (int k = 0; k < 8; k++) chk($sformatf("trace[%0d]", k), 32'(trace[k]), 32'(exp_trace[k]));
         end
      end

      // Reset while a load is waiting in MEM
      v = mk("lw_rst", C_LD, 3'b010, 0, 0, 32'h4000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(v);
      mem_wait = 0;
      while (state != S_MEM && mem_wait < 20) begin
         @(negedge clk);
         mem_wait++;
         imem_ready = 1'b1;
      end
      chk("mid state", 32'(state), 32'(S_MEM));
      chk("mid dmem_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort state", 32'(state), 32'(S_FETCH));
      chk("abort pc", pc, 32'h0);
      chk("abort dmem_req", 32'(dmem_req), 32'd0);
      chk("abort retire/rf_we", 32'({retire, rf_we}), 32'd0);
      $display("txn lw_rst     aborted in MEM pc=%h", pc);
      rst = 1'b0;

      // PC wrap: jump to the last word, then a plain ALU op
      run_vec(mk("jal_top", C_JAL, 3'b000, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 7, 0));
      run_vec(mk("addi_wrap", C_ALU, 3'b000, 0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0, 0, 7, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It owns the PC and steps one instruction at a time through fetch, decode, register read, execute, memory and writeback. It drives the 3-bit `state` bus consumed by the ALU, which evaluates in state 5. It also resolves branches, issues instruction/data memory handshakes and gates register-file writes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_TIMEOUT, 0, cycles to wait for imem_ready before restarting the fetch; 0 = wait forever.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction word valid on the fetch bus this cycle.
- is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc  in  1 each  decoded instruction class.
- rd_nonzero  in  1  rd field != 0.
- funct3  in  3  instruction funct3.
- rs1_val, rs2_val  in  32 each  register-file read data.
- alu_result, alu_address  in  32 each  ALU outputs.
- dmem_ready  in  1  data access complete.
- state  out  3  sequencer state, encoding below.
- pc  out  32  current instruction address.
- imem_req  out  1  fetch request.
- ir_we  out  1  latch the instruction register.
- dmem_req  out  1  data request.
- dmem_we  out  1  store strobe.
- dmem_addr  out  32  registered alu_address.
- rf_we  out  1  register-file write enable.
- retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- State encoding: 0 FETCH, 1 FETCH_WAIT, 2 DECODE, 3 REG_READ, 4 OPERAND, 5 EXECUTE, 6 MEM, 7 WRITEBACK.
- Reset: state=0, pc=RESET_PC. imem_req, ir_we, dmem_req, dmem_we, rf_we and retire are all 0. dmem_addr=0.
- Reset mid-operation aborts immediately. No pending access is completed.

Transitions:
- FETCH→FETCH_WAIT, with imem_req=1.
- FETCH_WAIT: imem_req stays 1.
  - imem_ready → DECODE, with ir_we=1 for exactly this cycle.
  - If IMEM_TIMEOUT>0 and the wait counter reaches IMEM_TIMEOUT, return to FETCH.
- DECODE→REG_READ→OPERAND→EXECUTE, one cycle each.
- EXECUTE (ALU evaluates combinationally): register alu_address into dmem_addr.
  - load/store → MEM.
  - otherwise → WRITEBACK.
- MEM: dmem_req=1, and dmem_we=is_store.
  - Hold until dmem_ready, then → WRITEBACK.
  - dmem_ready arriving in the first MEM cycle is legal; minimum MEM dwell is 1 cycle.
- WRITEBACK → FETCH, with retire=1.
  - rf_we=1 iff rd_nonzero and not (is_store or is_branch).

PC update (at WRITEBACK only, 32-bit wrap):
- jal/jalr: pc = alu_address with bit 0 cleared.
- Branch taken: pc = alu_address.
- Otherwise: pc = pc+4.

Branch condition, evaluated in EXECUTE and registered:
- funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
- 010/011 → not taken.

Latency: non-memory instruction = 7 cycles with zero-wait imem. Memory instruction = 8 cycles minimum.

Inputs other than imem_ready/dmem_ready are sampled only in their consuming state. Changes elsewhere are ignored.

Optional Feature:
- Macro: CPU_SEQ_MISALIGN_TRAP_EN.
- When defined, a misaligned access is detected in EXECUTE:
  - load/store with funct3[1:0]=10 and addr[1:0]!=0; or
  - funct3[1:0]=01 and addr[0]=1; or
  - jal/jalr/taken branch whose target has addr[1]=1.
- On detection: skip MEM, suppress rf_we, and set pc = TRAP_VEC (package constant 32'h0000_0100) at WRITEBACK.
- An extra output `trap` pulses with retire.
- When undefined: no checks, no `trap` port, and accesses issue as-is.

Decomposition:
- Shared package cpu_pkg holds:
  - state localparams (S_FETCH..S_WRITEBACK), so the ALU compares against S_EXECUTE instead of a literal;
  - funct3 branch codes;
  - TRAP_VEC.
- One sub-module, branch_cmp: combinational compare of rs1_val/rs2_val by funct3, output taken.

Test Plan:
- Reset released, imem_ready tied 1, addi decoded → state sequence 0,1,2,3,4,5,7,0; retire at cycle 7; pc 0→4; rf_we=1 only in WRITEBACK.
- beq with rs1=rs2=5, alu_address=0x40 → pc=0x40. Repeat with rs2=6 → pc=pc+4. blt with rs1=0xFFFFFFFF, rs2=1 → taken; bltu with the same operands → not taken.
- Load with dmem_ready delayed 3 cycles → dmem_req held 3 MEM cycles, dmem_we=0, dmem_addr=alu_address, rf_we in WRITEBACK. Store → dmem_we=1, rf_we=0.
- jalr with alu_address=0x1003 → pc=0x1002; rd=x0 (rd_nonzero=0) → rf_we=0.
- rst asserted during MEM with dmem_req high → next cycle state=0, pc=RESET_PC, dmem_req=0. Also pc=0xFFFFFFFC + addi → pc wraps to 0.
- CPU_SEQ_MISALIGN_TRAP_EN defined, lw with alu_address=0x102 → no dmem_req, trap=1, pc=0x100. Undefined build → normal MEM access.
